// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped I/O: word RAM, synchronised input port
// with change detection, output registers and a compare timer with irq.
module dmem_mmio #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int N_OUT      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [3:0]             be,
    input  logic [31:0]            a,
    input  logic [31:0]            wd,
    output logic [31:0]            rd,
    input  logic [IN_W-1:0]        in_port,
    output logic [N_OUT*OUT_W-1:0] out_port,
    output logic                   irq
);

    localparam int          WORDS    = 1 << DEPTH_LOG2;
    localparam logic [31:0] RAM_BASE = 32'h0000_1000;
    localparam logic [31:0] RAM_END  = RAM_BASE + 32'(4 * WORDS);

    localparam logic [29:0] A_IN_DATA = 30'h1FC0;
    localparam logic [29:0] A_IN_CHG  = 30'h1FC1;
    localparam logic [29:0] A_IN_MASK = 30'h1FC2;
    localparam logic [29:0] A_OUT     = 30'h1FC4;
    localparam logic [29:0] A_TCNT    = 30'h1FD0;
    localparam logic [29:0] A_TCMP    = 30'h1FD1;
    localparam logic [29:0] A_TCTRL   = 30'h1FD2;
    localparam logic [29:0] A_TSTAT   = 30'h1FD3;

    logic [31:0] mem [WORDS];

    logic [29:0]           wa;
    logic                  ram_hit;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  hit_data, hit_chg, hit_mask;
    logic                  hit_tcnt, hit_tcmp, hit_tctrl, hit_tstat;
    logic [N_OUT-1:0]      hit_out;

    logic [IN_W-1:0] sync1_q, sync1_d;
    logic [IN_W-1:0] sync2_q, sync2_d;
    logic [IN_W-1:0] prev_q, prev_d;
    logic [IN_W-1:0] chg_q, chg_d;
    logic [IN_W-1:0] mask_q, mask_d;
    logic [N_OUT-1:0][OUT_W-1:0] out_q, out_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        en_q, en_d;
    logic        match_q, match_d;

    assign wa       = a[31:2];
    assign ram_hit  = (a >= RAM_BASE) && (a < RAM_END);
    assign ram_idx  = a[DEPTH_LOG2+1:2];
    assign out_port = out_q;
    assign irq      = (|(chg_q & mask_q)) | match_q;

    // Register address decode
    always_comb begin
        hit_data  = (wa == A_IN_DATA);
        hit_chg   = (wa == A_IN_CHG);
        hit_mask  = (wa == A_IN_MASK);
        hit_tcnt  = (wa == A_TCNT);
        hit_tcmp  = (wa == A_TCMP);
        hit_tctrl = (wa == A_TCTRL);
        hit_tstat = (wa == A_TSTAT);
        hit_out   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            hit_out[k] = (wa == A_OUT + 30'(k));
        end
    end

    // Combinational read mux; unmapped space reads as zero
    always_comb begin
        rd = '0;
        unique case (1'b1)
            ram_hit:   rd = mem[ram_idx];
            hit_data:  rd = 32'(sync2_q);
            hit_chg:   rd = 32'(chg_q);
            hit_mask:  rd = 32'(mask_q);
            hit_tcnt:  rd = tcnt_q;
            hit_tcmp:  rd = tcmp_q;
            hit_tctrl: rd = {31'b0, en_q};
            hit_tstat: rd = {31'b0, match_q};
            default:   rd = '0;
        endcase
        for (int k = 0; k < N_OUT; k++) begin
            if (hit_out[k]) begin
                rd = 32'(out_q[k]);
            end
        end
    end

    // Next-state: set events beat W1C clears, bus writes beat counting
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        chg_d   = chg_q;
        if (we && hit_chg) begin
            chg_d = chg_q & ~wd[IN_W-1:0];
        end
        chg_d  = chg_d | (sync2_q ^ prev_q);
        mask_d = mask_q;
        if (we && hit_mask) begin
            mask_d = wd[IN_W-1:0];
        end
        out_d = out_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (we && hit_out[k]) begin
                out_d[k] = wd[OUT_W-1:0];
            end
        end
        tcnt_d = en_q ? tcnt_q + 32'd1 : tcnt_q;
        if (we && hit_tcnt) begin
            tcnt_d = wd;
        end
        tcmp_d = (we && hit_tcmp) ? wd : tcmp_q;
        en_d   = (we && hit_tctrl) ? wd[0] : en_q;
        match_d = match_q;
        if (we && hit_tstat && wd[0]) begin
            match_d = 1'b0;
        end
        if (en_q && (tcnt_q == tcmp_q)) begin
            match_d = 1'b1;
        end
    end

    // Register state with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            chg_q   <= '0;
            mask_q  <= '0;
            out_q   <= '0;
            tcnt_q  <= '0;
            tcmp_q  <= '0;
            en_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            chg_q   <= chg_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            en_q    <= en_d;
            match_q <= match_d;
        end
    end

    // RAM byte writes; contents survive reset but writes are held off
    always_ff @(posedge clk) begin
        if (we && rst_n && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[ram_idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed and randomised bench for dmem_mmio
// against a behavioural model of the memory map.
module tb_dmem_mmio;

  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int N_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [IN_W-1:0] in_port = '0;
  logic [N_OUT*OUT_W-1:0] out_port;
  logic        irq;

  dmem_mmio #(
    .DEPTH_LOG2(4),
    .IN_W(IN_W),
    .OUT_W(OUT_W),
    .N_OUT(N_OUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .be(be),
    .a(a),
    .wd(wd),
    .rd(rd),
    .in_port(in_port),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int kind,
                     input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] act;
    if (kind == 0) a = addr;
    #1;
    case (kind)
      0:       act = rd;
      1:       act = 32'(out_port);
      default: act = {31'b0, irq};
    endcase
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
    #1;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] addr,
                        input logic [31:0] exp);
    chk(nm, 0, addr, exp);
  endtask

  task automatic chk_out(input string nm, input logic [31:0] exp);
    chk(nm, 1, 32'h0, exp);
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    chk(nm, 2, 32'h0, {31'b0, exp});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] bes);
    a  = addr;
    wd = data;
    be = bes;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    be = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  logic [31:0] mem_m [16];
  logic [15:0] out_m [2];
  logic [15:0] chg_m, mask_m, in_m;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, idx, k, c;
    logic [31:0] ad, d, x;
    logic [3:0]  b;
    logic [15:0] v, m;

    out_m[0] = '0; out_m[1] = '0;
    chg_m = '0; mask_m = '0; in_m = '0;

    tick(3);
    #1;
    n_chk++;
    if (out_port === '0) n_pass++;
    else $display("FAIL rst_out: got %h want 0", out_port);
    chk_irq("rst_irq", 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk_rd("rst_tcnt", 32'h7F40, 32'h0);
    chk_rd("rst_chg", 32'h7F04, 32'h0);
    chk_rd("rst_data", 32'h7F00, 32'h0);
    chk_rd("rst_tstat", 32'h7F4C, 32'h0);
    tick(3);
    chk_rd("rel_chg", 32'h7F04, 32'h0);

    wr(32'h1004, 32'hAABBCCDD, 4'b1111);
    wr(32'h1004, 32'h11223344, 4'b0010);
    mem_m[1] = 32'hAABB33DD;
    a = 32'h1004;
    #1;
    n_chk++;
    if (rd === 32'hAABB33DD) n_pass++;
    else $display("FAIL ram_be: got %h want AABB33DD", rd);
    chk_rd("unmap_2000", 32'h2000, 32'h0);
    for (int i = 0; i < 16; i++) begin
      if (i != 1) begin
        mem_m[i] = $urandom;
        wr(32'h1000 + 32'(4 * i), mem_m[i], 4'b1111);
      end
    end
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      ad = 32'h1000 + 32'(4 * idx) + 32'($urandom_range(0, 3));
      if (sel < 4) begin
        d = $urandom;
        b = 4'($urandom_range(0, 15));
        wr(ad, d, b);
        mem_m[idx] = merge(mem_m[idx], d, b);
      end else if (sel < 8) begin
        chk_rd("ram_rd", ad, mem_m[idx]);
        tick(1);
      end else begin
        case ($urandom_range(0, 2))
          0:       ad = 32'h1040;
          1:       ad = 32'h0FFC;
          default: ad = 32'h1000 + 32'($urandom_range(64, 255)) * 4;
        endcase
        if (sel == 8) wr(ad, $urandom, 4'b1111);
        else begin
          chk_rd("unmap_rd", ad, 32'h0);
          tick(1);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      chk_rd("ram_all", 32'h1000 + 32'(4 * i), mem_m[i]);
      tick(1);
    end

    wr(32'h7F10, 32'h1234, 4'b0000);
    wr(32'h7F14, 32'hBEEF, 4'b0000);
    out_m[0] = 16'h1234; out_m[1] = 16'hBEEF;
    #1;
    n_chk++;
    if (out_port === 32'hBEEF1234) n_pass++;
    else $display("FAIL out_dir: got %h want BEEF1234", out_port);
    chk_rd("out1_rd", 32'h7F14, 32'h0000BEEF);
    wr(32'h7F18, 32'hFFFFFFFF, 4'b1111);
    chk_out("out_unmap_wr", 32'hBEEF1234);
    chk_rd("unmap_7f18", 32'h7F18, 32'h0);
    chk_rd("unmap_7f0c", 32'h7F0C, 32'h0);
    chk_rd("unmap_7f50", 32'h7F50, 32'h0);
    for (int n = 0; n < 12; n++) begin
      k = $urandom_range(0, 1);
      d = $urandom;
      wr(32'h7F10 + 32'(4 * k), d, 4'($urandom_range(0, 15)));
      out_m[k] = d[15:0];
      chk_out("out_rnd", {out_m[1], out_m[0]});
      chk_rd("out_rnd_rd", 32'h7F10 + 32'(4 * k), {16'h0, out_m[k]});
    end

    wr(32'h7F08, 32'h1, 4'b0000);
    mask_m = 16'h1;
    chk_rd("mask_rd", 32'h7F08, 32'h1);
    in_port[0] = 1'b1;
    tick(2);
    chk_rd("in_lat2", 32'h7F00, 32'h1);
    chk_rd("chg_early", 32'h7F04, 32'h0);
    chk_irq("irq_early", 1'b0);
    tick(1);
    a = 32'h7F04;
    #1;
    n_chk++;
    if (rd === 32'h1) n_pass++;
    else $display("FAIL chg_set: got %h want 1", rd);
    chk_irq("irq_chg", 1'b1);
    wr(32'h7F04, 32'h1, 4'b0000);
    chk_rd("chg_w1c", 32'h7F04, 32'h0);
    chk_irq("irq_clr", 1'b0);
    in_port[1] = 1'b1;
    tick(3);
    chk_rd("chg_b1", 32'h7F04, 32'h2);
    in_port[1] = 1'b0;
    tick(2);
    wr(32'h7F04, 32'h2, 4'b0000);
    chk_rd("chg_race", 32'h7F04, 32'h2);
    wr(32'h7F04, 32'h2, 4'b0000);
    chk_rd("chg_race_clr", 32'h7F04, 32'h0);
    in_m = 16'h1;
    for (int n = 0; n < 8; n++) begin
      v = 16'($urandom);
      in_port = v;
      tick(3);
      chg_m = chg_m | (in_m ^ v);
      in_m = v;
      chk_rd("in_rnd", 32'h7F00, {16'h0, in_m});
      chk_rd("chg_rnd", 32'h7F04, {16'h0, chg_m});
      m = 16'($urandom);
      wr(32'h7F08, {16'hFFFF, m}, 4'b0000);
      mask_m = m;
      chk_irq("irq_rnd", |(chg_m & mask_m));
      c = $urandom;
      wr(32'h7F04, 32'(c), 4'b0000);
      chg_m = chg_m & ~c[15:0];
      chk_rd("chg_w1c_rnd", 32'h7F04, {16'h0, chg_m});
      chk_irq("irq_w1c_rnd", |(chg_m & mask_m));
    end
    wr(32'h7F08, 32'h0, 4'b0000);
    mask_m = '0;

    wr(32'h7F44, 32'h5, 4'b0000);
    wr(32'h7F40, 32'h0, 4'b0000);
    wr(32'h7F48, 32'h1, 4'b0000);
    chk_rd("tcnt_start", 32'h7F40, 32'h0);
    chk_rd("tctrl_rd", 32'h7F48, 32'h1);
    chk_rd("tcmp_rd", 32'h7F44, 32'h5);
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      chk_rd("tcnt_cnt", 32'h7F40, 32'(n));
      chk_rd("tstat_cnt", 32'h7F4C, {31'b0, n >= 6});
      chk_irq("irq_tmr", n >= 6);
    end
    wr(32'h7F4C, 32'h1, 4'b0000);
    chk_rd("tstat_clr", 32'h7F4C, 32'h0);
    chk_irq("irq_tclr", 1'b0);
    wr(32'h7F40, 32'h5, 4'b0000);
    wr(32'h7F4C, 32'h1, 4'b0000);
    a = 32'h7F4C;
    #1;
    n_chk++;
    if (rd === 32'h1) n_pass++;
    else $display("FAIL tstat_race: got %h want 1", rd);
    wr(32'h7F40, 32'hFFFFFFFF, 4'b0000);
    chk_rd("tcnt_load", 32'h7F40, 32'hFFFFFFFF);
    tick(1);
    chk_rd("tcnt_wrap", 32'h7F40, 32'h0);
    for (int n = 0; n < 4; n++) begin
      x = $urandom;
      wr(32'h7F40, x, 4'b0000);
      c = $urandom_range(1, 20);
      tick(c);
      chk_rd("tcnt_rnd", 32'h7F40, x + 32'(c));
    end
    wr(32'h7F48, 32'h0, 4'b0000);
    x = $urandom;
    wr(32'h7F40, x, 4'b0000);
    tick(3);
    chk_rd("tcnt_hold", 32'h7F40, x);

    wr(32'h7F10, 32'hFFFF, 4'b0000);
    out_m[0] = 16'hFFFF;
    wr(32'h7F48, 32'h1, 4'b0000);
    wr(32'h7F40, 32'h5, 4'b0000);
    tick(1);
    chk_irq("irq_pre_rst", 1'b1);
    chk_out("out_pre_rst", {out_m[1], out_m[0]});
    tick(1);
    rst_n = 1'b0;
    chk_out("out_async", 32'h0);
    chk_irq("irq_async", 1'b0);
    chk_rd("tcnt_async", 32'h7F40, 32'h0);
    a  = 32'h1000;
    wd = ~mem_m[0];
    be = 4'b1111;
    we = 1'b1;
    tick(2);
    we = 1'b0;
    be = '0;
    rst_n = 1'b1;
    tick(2);
    a = 32'h1000;
    #1;
    n_chk++;
    if (rd === mem_m[0]) n_pass++;
    else $display("FAIL ram_keep: got %h want %h", rd, mem_m[0]);
    chk_rd("ram_keep1", 32'h1004, mem_m[1]);
    chk_out("out_post", 32'h0);
    chk_rd("tcnt_post", 32'h7F40, 32'h0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4; RAM holds 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter IN_W, default 16; input port width, 1..32.
REQ-003 SHALL have parameter OUT_W, default 16; width of each output port, 1..32.
REQ-004 SHALL have parameter N_OUT, default 2; number of output ports, 1..8.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port we  in  1  bus write strobe.
REQ-008 SHALL have port be  in  4  byte enables; be[i] selects wd[8i+7:8i].
REQ-009 SHALL have port a  in  32  byte address; a[1:0] ignored.
REQ-010 SHALL have port wd  in  32  write data.
REQ-011 SHALL have port rd  out  32  read data, combinational from a and state.
REQ-012 SHALL have port in_port  in  IN_W  asynchronous external inputs.
REQ-013 SHALL have port out_port  out  N_OUT*OUT_W  port k on bits [k*OUT_W +: OUT_W].
REQ-014 SHALL have port irq  out  1  level interrupt request.

Function
REQ-015 SHALL map RAM at 0x1000 up to 0x1000+4*2^DEPTH_LOG2-1, word index a[DEPTH_LOG2+1:2].
REQ-016 SHALL write RAM bytes with be[i]=1 only when we=1 and a is in RAM range; other bytes unchanged.
REQ-017 SHALL map registers: 0x7F00 IN_DATA (RO), 0x7F04 IN_CHG (W1C), 0x7F08 IN_MASK (RW), 0x7F10+4k OUT_k (RW, k<N_OUT), 0x7F40 TCNT (RW), 0x7F44 TCMP (RW), 0x7F48 TCTRL bit0 enable (RW), 0x7F4C TSTAT bit0 match (W1C).
REQ-018 SHALL ignore be for register writes (full word); register fields narrower than 32 bits take wd LSBs.
REQ-019 SHALL return unused upper bits as 0 and return 0 for reads of any unmapped address; writes to unmapped addresses have no effect.
REQ-020 SHALL pass in_port through a 2-flop synchroniser; IN_DATA is the second-stage value (2-cycle latency).
REQ-021 SHALL set IN_CHG[i] on the cycle after IN_DATA[i] differs from its previous-cycle value; bits sticky until cleared.
REQ-022 SHALL clear IN_CHG[i] when written with wd[i]=1; a simultaneous change event on bit i wins (bit stays 1).
REQ-023 SHALL drive out_port directly from OUT_k registers.
REQ-024 SHALL increment TCNT by 1 each cycle while TCTRL.enable=1, wrapping 0xFFFFFFFF to 0.
REQ-025 SHALL give a write to TCNT priority over the increment in the same cycle.
REQ-026 SHALL set TSTAT.match on the edge following any cycle where enable=1 and TCNT==TCMP.
REQ-027 SHALL clear TSTAT.match on a W1C write with wd[0]=1; a simultaneous match event wins.
REQ-028 SHALL drive irq = |(IN_CHG & IN_MASK) | TSTAT.match, combinationally from registers.
REQ-029 SHALL give reads combinational zero-wait access to RAM and registers.

Reset
REQ-030 SHALL, while rst_n=0, force synchroniser stages, IN_CHG, IN_MASK, OUT_k, TCNT, TCMP, TCTRL, TSTAT to 0, so out_port=0 and irq=0.
REQ-031 SHALL NOT reset RAM contents; RAM writes are blocked while rst_n=0.
REQ-032 SHALL not set IN_CHG on the first cycles after reset release unless IN_DATA departs from 0.

Verification
REQ-033 Write 0xAABBCCDD to 0x1004 be=1111, then 0x11223344 be=0010 -> read 0x1004 = 0xAABB33DD; read 0x2000 = 0.
REQ-034 Write 0x1234 to 0x7F10 and 0xBEEF to 0x7F14 -> out_port = {0xBEEF,0x1234}; read 0x7F14 = 0x0000BEEF.
REQ-035 IN_MASK=0x0001, toggle in_port[0] 0->1 -> IN_DATA=1 after 2 edges, IN_CHG=0x0001 next edge, irq=1; write 0x0001 to 0x7F04 -> irq=0.
REQ-036 TCMP=5, TCNT=0, enable=1 -> TSTAT=1 on edge after TCNT reaches 5, irq=1; TCNT load 0xFFFFFFFF -> wraps to 0.
REQ-037 W1C to IN_CHG in same cycle as new change on that bit -> bit remains 1.
REQ-038 Assert rst_n low mid-count with OUT_0=0xFFFF -> out_port, TCNT, irq 0 immediately; earlier RAM data still readable after release.
